// File: rtl/hqm_AW_pkg.sv
// Shared AW-library types: RMW pipe command encoding and a constant log2 helper.
package hqm_AW_pkg;

  typedef enum logic [1:0] {
    HQM_AW_RMWPIPE_NOOP  = 2'd0,
    HQM_AW_RMWPIPE_READ  = 2'd1,
    HQM_AW_RMWPIPE_WRITE = 2'd2,
    HQM_AW_RMWPIPE_RMW   = 2'd3
  } aw_rmwpipe_cmd_t;

  // Floor of log2; returns 0 for inputs of 0 or 1.
  function automatic int AW_logb2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 32'sd0) begin
        r = i;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hqm_lsp_atm_rmw_sched_pkg.sv
// LSP atomic RMW scheduler shared types; the state enum is decoded by status/debug CSRs.
package hqm_lsp_atm_rmw_sched_pkg;

  typedef enum logic [1:0] {
    LSP_RMW_INIT  = 2'd0,
    LSP_RMW_RUN   = 2'd1,
    LSP_RMW_DRAIN = 2'd2
  } lsp_rmw_sched_state_t;

  localparam int LSP_RMW_NUM_REQ = 32'sd2;

endpackage

// File: rtl/hqm_lsp_atm_rmw_sched_chk.sv
// Protocol checker: the scheduler must never present a p0 command while p0 is stalled.
module hqm_lsp_atm_rmw_sched_chk (
  input logic clk,
  input logic rst_n,
  input logic p0_v_nxt,
  input logic p0_hold
);

  // Sample the p0 handshake at each active edge outside reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(p0_v_nxt && p0_hold))
        else $error("p0_v_nxt asserted while p0_hold is high");
    end
  end

endmodule

// File: rtl/hqm_lsp_rr_arb2.sv
// Two-way round-robin grant; the most recently accepted requester loses the next tie.
module hqm_lsp_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant selection; requester 0 wins the first tie because last_grant resets to 1.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_grant_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
  end

  // Remember the winner only when its command was actually taken by the pipe.
  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) begin
      last_grant_d = gnt_o[1];
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/hqm_lsp_atm_rmw_sched.sv
// Front-end sequencer for the LSP atomic RMW pipe: RAM init walk, 2-way p0 arbitration,
// parity-error counting and idle reporting.
module hqm_lsp_atm_rmw_sched
  import hqm_AW_pkg::*;
  import hqm_lsp_atm_rmw_sched_pkg::*;
#(
  parameter int                DEPTH     = 8,
  parameter int                WIDTH     = 13,
  parameter logic [WIDTH-1:0]  INIT_DATA = 13'h1000,
  parameter int                DEPTHB2   = AW_logb2(DEPTH - 1) + 1,
  parameter int                ERRW      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_init_start,
  output logic                init_done,
  input  logic                req0_v,
  input  aw_rmwpipe_cmd_t     req0_rw,
  input  logic [DEPTHB2-1:0]  req0_addr,
  input  logic [WIDTH-1:0]    req0_data,
  output logic                req0_rdy,
  input  logic                req1_v,
  input  aw_rmwpipe_cmd_t     req1_rw,
  input  logic [DEPTHB2-1:0]  req1_addr,
  input  logic [WIDTH-1:0]    req1_data,
  output logic                req1_rdy,
  output logic                p0_v_nxt,
  output aw_rmwpipe_cmd_t     p0_rw_nxt,
  output logic [DEPTHB2-1:0]  p0_addr_nxt,
  output logic [WIDTH-1:0]    p0_write_data_nxt,
  input  logic                p0_hold,
  input  logic                p0_v_f,
  input  logic                p1_v_f,
  input  logic                p2_v_f,
  input  logic                p3_v_f,
  input  logic                pipe_error,
  input  logic                err_clr,
  output logic [ERRW-1:0]     err_cnt,
  output logic                err_sticky,
  output logic                idle
);

  localparam logic [DEPTHB2-1:0] LAST_PTR = DEPTHB2'(DEPTH - 1);
  localparam logic [DEPTHB2-1:0] PTR_ONE  = DEPTHB2'(1);
  localparam logic [ERRW-1:0]    ERR_ONE  = ERRW'(1);

  lsp_rmw_sched_state_t state_q, state_d;
  logic [DEPTHB2-1:0]   init_ptr_q, init_ptr_d;
  logic [ERRW-1:0]      err_cnt_q, err_cnt_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [1:0] arb_gnt_s;
  logic       arb_en_s;
  logic       arb_accept_s;
  logic       stages_busy_s;

  assign stages_busy_s = p0_v_f | p1_v_f | p2_v_f | p3_v_f;
  assign arb_en_s      = (state_q == LSP_RMW_RUN);
  assign arb_accept_s  = (|arb_gnt_s) & ~p0_hold;

  hqm_lsp_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (arb_en_s),
    .req_i    ({req1_v, req0_v}),
    .accept_i (arb_accept_s),
    .gnt_o    (arb_gnt_s)
  );

  // Sequencer next state and the p0 command mux; acceptance is zero-latency.
  always_comb begin
    state_d           = state_q;
    init_ptr_d        = init_ptr_q;
    p0_v_nxt          = 1'b0;
    p0_rw_nxt         = HQM_AW_RMWPIPE_NOOP;
    p0_addr_nxt       = '0;
    p0_write_data_nxt = '0;
    req0_rdy          = 1'b0;
    req1_rdy          = 1'b0;
    case (state_q)
      LSP_RMW_INIT: begin
        // A stalled init write is simply re-presented; only unheld cycles advance.
        p0_v_nxt          = ~p0_hold;
        p0_rw_nxt         = HQM_AW_RMWPIPE_WRITE;
        p0_addr_nxt       = init_ptr_q;
        p0_write_data_nxt = INIT_DATA;
        if (!p0_hold) begin
          if (init_ptr_q == LAST_PTR) begin
            init_ptr_d = '0;
            state_d    = LSP_RMW_RUN;
          end else begin
            init_ptr_d = init_ptr_q + PTR_ONE;
          end
        end else begin
          init_ptr_d = init_ptr_q;
        end
      end
      LSP_RMW_RUN: begin
        req0_rdy = arb_gnt_s[0] & ~p0_hold;
        req1_rdy = arb_gnt_s[1] & ~p0_hold;
        if (arb_gnt_s[1]) begin
          p0_v_nxt          = ~p0_hold;
          p0_rw_nxt         = req1_rw;
          p0_addr_nxt       = req1_addr;
          p0_write_data_nxt = req1_data;
        end else if (arb_gnt_s[0]) begin
          p0_v_nxt          = ~p0_hold;
          p0_rw_nxt         = req0_rw;
          p0_addr_nxt       = req0_addr;
          p0_write_data_nxt = req0_data;
        end else begin
          p0_v_nxt = 1'b0;
        end
        if (cfg_init_start) begin
          state_d = LSP_RMW_DRAIN;
        end else begin
          state_d = state_q;
        end
      end
      LSP_RMW_DRAIN: begin
        if (!stages_busy_s) begin
          state_d    = LSP_RMW_INIT;
          init_ptr_d = '0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = LSP_RMW_INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  // Saturating parity-error counter; clear wins over a coincident error.
  always_comb begin
    err_cnt_d    = err_cnt_q;
    err_sticky_d = err_sticky_q;
    if (err_clr) begin
      err_cnt_d    = '0;
      err_sticky_d = 1'b0;
    end else if (pipe_error) begin
      err_cnt_d    = (&err_cnt_q) ? err_cnt_q : (err_cnt_q + ERR_ONE);
      err_sticky_d = 1'b1;
    end else begin
      err_cnt_d    = err_cnt_q;
      err_sticky_d = err_sticky_q;
    end
  end

  // State, init pointer and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LSP_RMW_INIT;
      init_ptr_q   <= '0;
      err_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      err_cnt_q    <= err_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign init_done  = (state_q == LSP_RMW_RUN);
  assign err_cnt    = err_cnt_q;
  assign err_sticky = err_sticky_q;
  assign idle       = (state_q == LSP_RMW_RUN) & ~req0_v & ~req1_v & ~stages_busy_s;

  hqm_lsp_atm_rmw_sched_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_v_nxt (p0_v_nxt),
    .p0_hold  (p0_hold)
  );

endmodule

// File: tb/tb_hqm_lsp_atm_rmw_sched.sv
// Self-checking bench: random requesters and pipe stalls against a transaction-level
// reference model, plus directed init, drain, error and async-reset scenarios.
module tb_hqm_lsp_atm_rmw_sched;
  import hqm_AW_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 13;
  localparam int AW    = 3;
  localparam int MODE_INIT = 0, MODE_RUN = 1, MODE_DRAIN = 2;

  logic clk, rst_n, cfg_init_start, init_done;
  logic req0_v, req1_v, req0_rdy, req1_rdy;
  aw_rmwpipe_cmd_t req0_rw, req1_rw, p0_rw_nxt;
  logic [AW-1:0] req0_addr, req1_addr, p0_addr_nxt;
  logic [W-1:0] req0_data, req1_data, p0_write_data_nxt;
  logic p0_v_nxt, p0_hold, p0_v_f, p1_v_f, p2_v_f, p3_v_f;
  logic pipe_error, err_clr, err_sticky, idle;
  logic [15:0] err_cnt;

  // Second instance with a narrow counter to reach saturation quickly.
  logic sat_perr, sat_clr, s_init_done, s_r0, s_r1, s_v, s_sticky, s_idle;
  aw_rmwpipe_cmd_t s_rw;
  logic [AW-1:0] s_addr;
  logic [W-1:0] s_data;
  logic [3:0] s_err_cnt;

  hqm_lsp_atm_rmw_sched u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_init_start(cfg_init_start), .init_done(init_done),
    .req0_v(req0_v), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_data(req0_data), .req0_rdy(req0_rdy),
    .req1_v(req1_v), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_data(req1_data), .req1_rdy(req1_rdy),
    .p0_v_nxt(p0_v_nxt), .p0_rw_nxt(p0_rw_nxt), .p0_addr_nxt(p0_addr_nxt),
    .p0_write_data_nxt(p0_write_data_nxt), .p0_hold(p0_hold),
    .p0_v_f(p0_v_f), .p1_v_f(p1_v_f), .p2_v_f(p2_v_f), .p3_v_f(p3_v_f),
    .pipe_error(pipe_error), .err_clr(err_clr), .err_cnt(err_cnt), .err_sticky(err_sticky), .idle(idle)
  );

  hqm_lsp_atm_rmw_sched #(.ERRW(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .cfg_init_start(1'b0), .init_done(s_init_done),
    .req0_v(1'b0), .req0_rw(HQM_AW_RMWPIPE_NOOP), .req0_addr(3'd0), .req0_data(13'd0), .req0_rdy(s_r0),
    .req1_v(1'b0), .req1_rw(HQM_AW_RMWPIPE_NOOP), .req1_addr(3'd0), .req1_data(13'd0), .req1_rdy(s_r1),
    .p0_v_nxt(s_v), .p0_rw_nxt(s_rw), .p0_addr_nxt(s_addr), .p0_write_data_nxt(s_data), .p0_hold(1'b0),
    .p0_v_f(1'b0), .p1_v_f(1'b0), .p2_v_f(1'b0), .p3_v_f(1'b0),
    .pipe_error(sat_perr), .err_clr(sat_clr), .err_cnt(s_err_cnt), .err_sticky(s_sticky), .idle(s_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nassert = 0;
  int nfail   = 0;

  // Reference model: pending requests per requester, remaining init addresses, error tally.
  int              m_state;
  int              init_q[$];
  int              m_last;
  int              m_err;
  bit              m_sticky;
  bit              pend[2];
  aw_rmwpipe_cmd_t prw[2];
  logic [AW-1:0]   paddr[2];
  logic [W-1:0]    pdata[2];
  int              rate[2];
  int              act_gnt[$];
  int              init_mask;
  logic [AW-1:0]   obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    nassert++;
    assert (obs === e) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic model_reset();
    m_state = MODE_INIT;
    init_q.delete();
    for (int i = 0; i < DEPTH; i++) init_q.push_back(i);
    m_last   = 1;
    m_err    = 0;
    m_sticky = 1'b0;
  endtask

  // One clock: present pending requests, check all outputs at negedge, advance the model.
  task automatic cycle();
    int win;
    bit e_v, e_r0, e_r1;
    int e_rw, e_addr, e_data;
    for (int r = 0; r < 2; r++) begin
      if (!pend[r] && ($urandom_range(99) < rate[r])) begin
        pend[r]  = 1'b1;
        prw[r]   = aw_rmwpipe_cmd_t'($urandom_range(3, 1));
        paddr[r] = AW'($urandom);
        pdata[r] = W'($urandom);
      end
    end
    req0_v = pend[0]; req0_rw = prw[0]; req0_addr = paddr[0]; req0_data = pdata[0];
    req1_v = pend[1]; req1_rw = prw[1]; req1_addr = paddr[1]; req1_data = pdata[1];
    @(negedge clk);
    if (!rst_n) model_reset();
    win = -1; e_v = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0;
    e_rw = 0; e_addr = 0; e_data = 0;
    if (m_state == MODE_INIT) begin
      e_v = !p0_hold; e_rw = 2; e_addr = init_q[0]; e_data = 32'h1000;
    end else if (m_state == MODE_RUN) begin
      if (pend[0] && pend[1]) win = (m_last == 0) ? 1 : 0;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
      if (win >= 0) begin
        e_v = !p0_hold; e_rw = int'(prw[win]); e_addr = int'(paddr[win]); e_data = int'(pdata[win]);
        if (win == 0) e_r0 = !p0_hold; else e_r1 = !p0_hold;
      end
    end
    chk("p0_v", p0_v_nxt, e_v);
    chk("p0_rw", p0_rw_nxt, e_rw);
    chk("p0_addr", p0_addr_nxt, e_addr);
    chk("p0_data", p0_write_data_nxt, e_data);
    chk("rdy0", req0_rdy, e_r0);
    chk("rdy1", req1_rdy, e_r1);
    chk("init_done", init_done, m_state == MODE_RUN);
    chk("idle", idle, (m_state == MODE_RUN) && !pend[0] && !pend[1] &&
                      !(p0_v_f | p1_v_f | p2_v_f | p3_v_f));
    chk("err_cnt", err_cnt, m_err);
    chk("err_sticky", err_sticky, m_sticky);
    obs_addr = p0_addr_nxt;
    if (m_state == MODE_INIT && p0_v_nxt) init_mask |= (1 << p0_addr_nxt);
    if (req0_rdy) act_gnt.push_back(0);
    if (req1_rdy) act_gnt.push_back(1);
    if (rst_n) begin
      if (m_state == MODE_INIT) begin
        if (!p0_hold) begin
          void'(init_q.pop_front());
          if (init_q.size() == 0) m_state = MODE_RUN;
        end
      end else if (m_state == MODE_RUN) begin
        if (win >= 0 && !p0_hold) begin
          m_last = win;
          pend[win] = 1'b0;
        end
        if (cfg_init_start) m_state = MODE_DRAIN;
      end else begin
        if (!(p0_v_f | p1_v_f | p2_v_f | p3_v_f)) begin
          m_state = MODE_INIT;
          for (int i = 0; i < DEPTH; i++) init_q.push_back(i);
        end
      end
      if (err_clr) begin
        m_err = 0; m_sticky = 1'b0;
      end else if (pipe_error) begin
        m_err = (m_err == 65535) ? 65535 : m_err + 1;
        m_sticky = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int cnt3;
    bit alt_ok;
    rst_n = 1'b0; cfg_init_start = 1'b0; p0_hold = 1'b0;
    {p0_v_f, p1_v_f, p2_v_f, p3_v_f} = 4'b0000;
    pipe_error = 1'b0; err_clr = 1'b0; sat_perr = 1'b0; sat_clr = 1'b0;
    rate[0] = 0; rate[1] = 0; pend[0] = 1'b0; pend[1] = 1'b0;
    prw[0] = HQM_AW_RMWPIPE_NOOP; prw[1] = HQM_AW_RMWPIPE_NOOP;
    paddr[0] = '0; paddr[1] = '0; pdata[0] = '0; pdata[1] = '0;
    model_reset();

    // Reset, then an unstalled init walk of addresses 0..7.
    cycle(); cycle();
    rst_n = 1'b1;
    init_mask = 0;
    for (int i = 0; i < DEPTH; i++) cycle();
    chk("init_all_addr", init_mask, 32'hFF);
    chk("init_done_at_8", init_done, 1'b1);

    // Random traffic with random stalls.
    rate[0] = 50; rate[1] = 50;
    for (int i = 0; i < 80; i++) begin
      p0_hold = ($urandom_range(99) < 20);
      cycle();
    end
    p0_hold = 1'b0;

    // Both requesters always valid: grants alternate, a stall does not disturb the order.
    rate[0] = 100; rate[1] = 100;
    cycle();
    act_gnt.delete();
    for (int i = 0; i < 12; i++) begin
      p0_hold = (i == 5);
      cycle();
    end
    p0_hold = 1'b0;
    alt_ok = (act_gnt.size() == 11);
    for (int i = 1; i < act_gnt.size(); i++) if (act_gnt[i] == act_gnt[i-1]) alt_ok = 1'b0;
    chk("grant_alternate", alt_ok, 1'b1);

    // Re-init request while p2 is busy: drain, then init with a 2-cycle stall at address 3.
    p2_v_f = 1'b1;
    cfg_init_start = 1'b1;
    cycle();
    cfg_init_start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("drain_no_done", init_done, 1'b0);
    p2_v_f = 1'b0;
    cycle();
    init_mask = 0; cnt3 = 0;
    for (k = 0; k < 40; k++) begin
      p0_hold = (k == 3 || k == 4);
      cycle();
      if (obs_addr == 3'd3) cnt3++;
      if (init_done) break;
    end
    p0_hold = 1'b0;
    chk("reinit_len", k + 1, 10);
    chk("reinit_addr", init_mask, 32'hFF);
    chk("addr3_held", cnt3, 3);
    for (int i = 0; i < 4; i++) cycle();

    // Error counting: three errors, then clear coincident with a fourth.
    rate[0] = 30; rate[1] = 30;
    pipe_error = 1'b1;
    cycle(); cycle(); cycle();
    pipe_error = 1'b0;
    cycle();
    chk("err_three", err_cnt, 16'd3);
    chk("err_sticky_set", err_sticky, 1'b1);
    pipe_error = 1'b1; err_clr = 1'b1;
    cycle();
    pipe_error = 1'b0; err_clr = 1'b0;
    cycle();
    chk("err_cleared", err_cnt, 16'd0);
    chk("sticky_cleared", err_sticky, 1'b0);

    // Saturation on the narrow-counter instance.
    sat_perr = 1'b1;
    for (int i = 0; i < 15; i++) cycle();
    chk("sat_full", s_err_cnt, 4'hF);
    cycle();
    chk("sat_hold", s_err_cnt, 4'hF);
    chk("sat_sticky", s_sticky, 1'b1);
    sat_clr = 1'b1;
    cycle();
    sat_perr = 1'b0; sat_clr = 1'b0;
    chk("sat_clr", s_err_cnt, 4'h0);
    chk("sat_sticky_clr", s_sticky, 1'b0);

    // Async reset in the middle of an init walk restarts from address 0.
    rate[0] = 0; rate[1] = 0;
    for (int i = 0; i < 3; i++) cycle();
    cfg_init_start = 1'b1;
    cycle();
    cfg_init_start = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    chk("ptr_at_5", p0_addr_nxt, 3'd5);
    rst_n = 1'b0;
    #1;
    chk("rst_addr0", p0_addr_nxt, 3'd0);
    chk("rst_done0", init_done, 1'b0);
    cycle();
    rst_n = 1'b1;
    init_mask = 0;
    cycle();
    chk("restart_addr0", obs_addr, 3'd0);
    for (int i = 0; i < 8; i++) cycle();
    chk("restart_all_addr", init_mask, 32'hFF);
    chk("restart_done", init_done, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
